hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
Parametrised hazard and forwarding controller for the pipelined RISC-V core. It tracks the destination registers of in-flight instructions in a NUM_STAGES-deep shadow pipeline behind ID. Each cycle it returns, for the instruction in ID, bypass selects and bypassed data for rs1 and rs2, or a stall request when an operand is not yet produced. It generalises the fixed per-signal delay chains with valid tracking, bubble insertion, flush, load-use detection and configurable result-ready stages.

Parameters:
NUM_STAGES, 3, tracked stages after ID (entry 0 = EX, entry NUM_STAGES-1 = WB)
XLEN, 32, data width
REG_ADDR_W, 5, register address width
ALU_READY, 0, first entry index where a non-load result is valid on stage_data
LOAD_READY, 1, first entry index where a load result is valid on stage_data (LOAD_READY >= ALU_READY, < NUM_STAGES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  source 1 address
id_rs2  in  REG_ADDR_W  source 2 address
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_ADDR_W  destination address
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
flush  in  1  taken branch/jump resolved in EX; kill ID and entry 0
stage_data  in  NUM_STAGES*XLEN  result presented by each tracked stage, slice k = entry k
rf_data1  in  XLEN  register-file read for rs1
rf_data2  in  XLEN  register-file read for rs2
stall  out  1  hold PC and ID this cycle
fwd_sel1  out  clog2(NUM_STAGES+1)  0 = register file, k+1 = entry k
fwd_sel2  out  clog2(NUM_STAGES+1)  as fwd_sel1 for rs2
fwd_data1  out  XLEN  selected operand 1
fwd_data2  out  XLEN  selected operand 2

Behaviour:
- State: NUM_STAGES entries {valid, rd, wr, is_load}. This is the only storage.
- Reset (sync): all entries invalid. While reset is high: stall=0, fwd_sel*=0, fwd_data*=rf_data*.
- Entries shift every clock with no freeze; entry k moves to k+1 and entry NUM_STAGES-1 is dropped.
- Entry 0 next value:
  - flush=1: invalid.
  - else stall=1: invalid (bubble).
  - else: {id_valid, id_rd, id_reg_write & (id_rd!=0), id_is_load}.
- flush also zeroes entry 0 before the shift, so the next-cycle entry 1 is invalid. Entries 1 and older shift normally.
- Match for operand r (r = rs1 or rs2): entry k with valid && wr && rd==r && r!=0.
- Only the youngest match (lowest k) counts; older matches are ignored.
- ready(k) = k >= (is_load ? LOAD_READY : ALU_READY).
- Operand resolution:
  - use bit clear, id_valid=0, or no match: sel=0, data=rf_data.
  - youngest match ready: sel=k+1, data=stage_data slice k.
  - youngest match not ready: operand hazard.
- stall = id_valid && !flush && (hazard on rs1 || hazard on rs2). Combinational, with no added latency.
- flush overrides stall; a flushed ID never stalls.
- Load-use with default parameters gives exactly 1 stall cycle, then the operand bypasses from entry 1.
- With ALU_READY=0 there are no ALU stalls. Non-zero ALU_READY stalls ALU_READY cycles for back-to-back use.
- Matching a WB entry (k=NUM_STAGES-1) still bypasses, so same-cycle register-file write/read ordering does not matter.
- Outputs are purely combinational from state and inputs; there is no registered output latency.

Test Plan:
- Defaults. Issue add x5, next cycle ID reads rs1=x5, stage_data[0]=0x11 -> stall=0, fwd_sel1=1, fwd_data1=0x11.
- Issue lw x6, next cycle ID reads rs2=x6 -> stall=1 for one cycle and entry 0 becomes a bubble. Following cycle: stall=0, fwd_sel2=2, fwd_data2=stage_data[1].
- Issue addi x0 followed by a read of x0 -> fwd_sel1=0, fwd_data1=rf_data1, stall=0.
- Back-to-back writes to x7 (entries 0 and 1, stage_data 0xA/0xB), then read x7 -> fwd_sel1=1, data 0xA.
- lw x8, next cycle use of x8 with flush=1 -> stall=0. Following cycle entries 0 and 1 are invalid and fwd_sel*=0.
- Load-use stall active, assert reset for one cycle -> all entries cleared; after reset stall=0 and fwd_sel*=0 for any rs.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: shadows destination registers of in-flight
// instructions behind ID and resolves rs1/rs2 to a bypass source or a stall.
module hazard_forward_unit #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_READY  = 0,
    parameter int unsigned LOAD_READY = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                id_valid,
    input  logic [REG_ADDR_W-1:0]               id_rs1,
    input  logic [REG_ADDR_W-1:0]               id_rs2,
    input  logic                                id_use_rs1,
    input  logic                                id_use_rs2,
    input  logic [REG_ADDR_W-1:0]               id_rd,
    input  logic                                id_reg_write,
    input  logic                                id_is_load,
    input  logic                                flush,
    input  logic [NUM_STAGES*XLEN-1:0]          stage_data,
    input  logic [XLEN-1:0]                     rf_data1,
    input  logic [XLEN-1:0]                     rf_data2,
    output logic                                stall,
    output logic [$clog2(NUM_STAGES+1)-1:0]     fwd_sel1,
    output logic [$clog2(NUM_STAGES+1)-1:0]     fwd_sel2,
    output logic [XLEN-1:0]                     fwd_data1,
    output logic [XLEN-1:0]                     fwd_data2
);

    localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

    typedef struct packed {
        logic             hazard;
        logic [SEL_W-1:0] sel;
        logic [XLEN-1:0]  data;
    } operand_t;

    logic [NUM_STAGES-1:0]                 valid_q, valid_d;
    logic [NUM_STAGES-1:0]                 wr_q, wr_d;
    logic [NUM_STAGES-1:0]                 load_q, load_d;
    logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] rd_q, rd_d;

    operand_t op1, op2;

    // Youngest matching entry decides: bypass if its result is ready, else hazard.
    function automatic operand_t resolve(input logic                  use_r,
                                         input logic [REG_ADDR_W-1:0] r,
                                         input logic [XLEN-1:0]       rf);
        operand_t res;
        logic     found;
        res.hazard = 1'b0;
        res.sel    = '0;
        res.data   = rf;
        found      = 1'b0;
        if (use_r && id_valid && (r != '0)) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (!found && valid_q[k] && wr_q[k] && (rd_q[k] == r)) begin
                    found = 1'b1;
                    if (k >= (load_q[k] ? LOAD_READY : ALU_READY)) begin
                        res.sel  = SEL_W'(k + 1);
                        res.data = stage_data[k*XLEN +: XLEN];
                    end else begin
                        res.hazard = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        op1       = resolve(id_use_rs1, id_rs1, rf_data1);
        op2       = resolve(id_use_rs2, id_rs2, rf_data2);
        stall     = !reset && id_valid && !flush && (op1.hazard || op2.hazard);
        fwd_sel1  = reset ? '0 : op1.sel;
        fwd_sel2  = reset ? '0 : op2.sel;
        fwd_data1 = reset ? rf_data1 : op1.data;
        fwd_data2 = reset ? rf_data2 : op2.data;
    end

    // Flush kills the EX entry before it shifts, so it lands in entry 1 as invalid.
    always_comb begin
        valid_d = '0;
        wr_d    = '0;
        load_d  = '0;
        rd_d    = '0;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            valid_d[k] = valid_q[k-1] && !(flush && (k == 1));
            wr_d[k]    = wr_q[k-1];
            load_d[k]  = load_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
        valid_d[0] = id_valid && !flush && !stall;
        wr_d[0]    = id_reg_write && (id_rd != '0);
        load_d[0]  = id_is_load;
        rd_d[0]    = id_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            wr_q    <= '0;
            load_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: per-cycle comparison against an
// instruction-history model plus hand-computed literal expectations.
module tb_hazard_forward_unit;

    localparam int NS    = 3;
    localparam int XL    = 32;
    localparam int AW    = 5;
    localparam int ALU_R = 0;
    localparam int LD_R  = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [AW-1:0]     id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2, id_reg_write, id_is_load, flush;
    logic [NS*XL-1:0]  stage_data;
    logic [XL-1:0]     rf_data1, rf_data2;
    logic              stall;
    logic [1:0]        fwd_sel1, fwd_sel2;
    logic [XL-1:0]     fwd_data1, fwd_data2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what each in-flight slot holds, as issued from ID.
    bit m_v  [NS];
    int m_rd [NS];
    bit m_rw [NS];
    bit m_ld [NS];

    hazard_forward_unit #(
        .NUM_STAGES(NS), .XLEN(XL), .REG_ADDR_W(AW),
        .ALU_READY(ALU_R), .LOAD_READY(LD_R)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .stage_data(stage_data),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_op(input bit u, input int r, input logic [31:0] rf,
                                     output bit hz, output int sel, output logic [31:0] d);
        hz  = 1'b0;
        sel = 0;
        d   = rf;
        if (!u || !id_valid || r == 0) return;
        for (int k = 0; k < NS; k++) begin
            if (m_v[k] && m_rw[k] && m_rd[k] == r) begin
                if (k >= (m_ld[k] ? LD_R : ALU_R)) begin
                    sel = k + 1;
                    d   = stage_data[k*XL +: XL];
                end else begin
                    hz = 1'b1;
                end
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        bit h1, h2;
        int s;
        logic [31:0] d;
        model_op(id_use_rs1, int'(id_rs1), rf_data1, h1, s, d);
        model_op(id_use_rs2, int'(id_rs2), rf_data2, h2, s, d);
        return id_valid && !flush && (h1 || h2);
    endfunction

    initial begin
        for (int k = 0; k < NS; k++) begin
            m_v[k] = 0; m_rd[k] = 0; m_rw[k] = 0; m_ld[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NS; k++) m_v[k] = 1'b0;
        end else begin
            bit s;
            s = model_stall();
            for (int k = NS - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1];
                m_rw[k] = m_rw[k-1]; m_ld[k] = m_ld[k-1];
            end
            if (flush) m_v[1] = 1'b0;
            m_v[0]  = id_valid && !flush && !s;
            m_rd[0] = int'(id_rd);
            m_rw[0] = id_reg_write;
            m_ld[0] = id_is_load;
        end
    end

    always @(negedge clk) begin
        bit h1, h2;
        int s1, s2;
        logic [31:0] d1, d2;
        bit exp_stall;
        if (reset) begin
            h1 = 0; h2 = 0; s1 = 0; s2 = 0; d1 = rf_data1; d2 = rf_data2;
            exp_stall = 1'b0;
        end else begin
            model_op(id_use_rs1, int'(id_rs1), rf_data1, h1, s1, d1);
            model_op(id_use_rs2, int'(id_rs2), rf_data2, h2, s2, d2);
            exp_stall = id_valid && !flush && (h1 || h2);
        end
        chk("m_stall", 32'(stall), 32'(exp_stall));
        chk("m_sel1", 32'(fwd_sel1), 32'(s1));
        chk("m_sel2", 32'(fwd_sel2), 32'(s2));
        chk("m_data1", fwd_data1, d1);
        chk("m_data2", fwd_data2, d2);
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit rw, input bit ld, input bit fl);
        id_valid     = v;
        id_rs1       = AW'(rs1);
        id_rs2       = AW'(rs2);
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = AW'(rd);
        id_reg_write = rw;
        id_is_load   = ld;
        flush        = fl;
    endtask

    task automatic drain();
        for (int i = 0; i < NS; i++) begin
            adv();
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        stage_data = {32'h33, 32'h22, 32'h11};
        rf_data1   = 32'hAAAA_0001;
        rf_data2   = 32'hBBBB_0002;
        set_id(1, 5, 6, 1, 1, 5, 1, 0, 0);
        smp();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_sel1", 32'(fwd_sel1), 32'd0);
        chk("rst_data2", fwd_data2, 32'hBBBB_0002);
        adv();
        reset = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // add x5 then read x5
        adv(); set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
        adv(); set_id(1, 5, 0, 1, 0, 0, 0, 0, 0);
        smp();
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_sel1", 32'(fwd_sel1), 32'd1);
        chk("alu_data1", fwd_data1, 32'h11);
        drain();

        // lw x6 then read x6 via rs2
        adv(); set_id(1, 0, 0, 0, 0, 6, 1, 1, 0);
        adv(); set_id(1, 0, 6, 0, 1, 0, 0, 0, 0);
        smp();
        chk("lu_stall", 32'(stall), 32'd1);
        adv(); smp();
        chk("lu_stall_after", 32'(stall), 32'd0);
        chk("lu_sel2", 32'(fwd_sel2), 32'd2);
        chk("lu_data2", fwd_data2, 32'h22);
        drain();

        // write x0 then read x0
        adv(); set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);
        adv(); set_id(1, 0, 0, 1, 0, 0, 0, 0, 0);
        smp();
        chk("x0_sel1", 32'(fwd_sel1), 32'd0);
        chk("x0_data1", fwd_data1, 32'hAAAA_0001);
        chk("x0_stall", 32'(stall), 32'd0);
        drain();

        // back-to-back writes of x7, youngest wins
        stage_data = {32'h33, 32'hB, 32'hA};
        adv(); set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        adv(); set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        adv(); set_id(1, 7, 0, 1, 0, 0, 0, 0, 0);
        smp();
        chk("yng_sel1", 32'(fwd_sel1), 32'd1);
        chk("yng_data1", fwd_data1, 32'hA);
        drain();

        // WB-stage bypass
        stage_data = {32'h33, 32'h22, 32'h11};
        adv(); set_id(1, 0, 0, 0, 0, 9, 1, 0, 0);
        adv(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); set_id(1, 0, 9, 0, 1, 0, 0, 0, 0);
        smp();
        chk("wb_sel2", 32'(fwd_sel2), 32'd3);
        chk("wb_data2", fwd_data2, 32'h33);
        drain();

        // lw x8, dependent use flushed
        adv(); set_id(1, 0, 0, 0, 0, 8, 1, 1, 0);
        adv(); set_id(1, 8, 0, 1, 0, 0, 0, 0, 1);
        smp();
        chk("fl_stall", 32'(stall), 32'd0);
        adv(); set_id(1, 8, 8, 1, 1, 0, 0, 0, 0);
        smp();
        chk("fl_sel1", 32'(fwd_sel1), 32'd0);
        chk("fl_sel2", 32'(fwd_sel2), 32'd0);
        chk("fl_stall_after", 32'(stall), 32'd0);
        drain();

        // load-use stall interrupted by reset
        adv(); set_id(1, 0, 0, 0, 0, 10, 1, 1, 0);
        adv(); set_id(1, 10, 10, 1, 1, 0, 0, 0, 0);
        smp();
        chk("rl_stall", 32'(stall), 32'd1);
        adv(); reset = 1'b1;
        smp();
        chk("rl_rst_sel1", 32'(fwd_sel1), 32'd0);
        chk("rl_rst_data1", fwd_data1, 32'hAAAA_0001);
        adv(); reset = 1'b0;
        smp();
        chk("rl_post_stall", 32'(stall), 32'd0);
        chk("rl_post_sel1", 32'(fwd_sel1), 32'd0);
        chk("rl_post_sel2", 32'(fwd_sel2), 32'd0);
        drain();

        adv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
